muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative multiply/divide sequencer and HI/LO register file for the multi-cycle MIPS core.
//  It replaces the single-cycle combinational p/q/r paths beside the ALU with a 1-bit-per-cycle
//  shift-add multiplier and a restoring divider. The control FSM stalls on busy and reads the
//  results through hi/lo (MFHI/MFLO); MTHI/MTLO write those registers directly.
// PARAMETERS
//  W        32   operand width; HI/LO are W bits each
//  CNT_W    6    iteration counter width; must satisfy 2**CNT_W > W
// PORTS
//  clk      in   1    core clock; all state changes on the rising edge
//  rst_n    in   1    asynchronous, active-low reset
//  start    in   1    request; sampled only in IDLE
//  func     in   6    000111 mult, 001011 multu, 010011 div, 100011 divu (ALU Func codes)
//  a        in   W    multiplicand / dividend (rs)
//  b        in   W    multiplier / divisor (rt)
//  flush    in   1    abort the in-flight operation (exception/redirect)
//  wr_hi    in   1    MTHI strobe
//  wr_lo    in   1    MTLO strobe
//  wdata    in   W    MTHI/MTLO data
//  busy     out  1    operation in flight; the core stalls MFHI/MFLO/new muldiv while high
//  done     out  1    one-cycle pulse; hi/lo hold the new result in the same cycle
//  hi       out  W    HI register
//  lo       out  W    LO register
//  div0     out  1    divide-by-zero flag (MULDIV_DIV0_EN only; otherwise tied 0)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, div0=0, counter=0.
//  FSM: IDLE -> RUN (W cycles) -> FIX (1 cycle) -> IDLE.
//  Accept: in IDLE, start=1 with a legal func latches the op, the signs, |a| and |b|
//    (magnitudes for signed ops, raw values for unsigned ops), clears the accumulator and counter,
//    and moves to RUN. busy rises on the next cycle.
//  A start with an illegal func is ignored: no state change, no busy.
//  start while busy is ignored; the core must not rely on queueing.
//  RUN mult: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2W
//    accumulator (W+1-bit add, carry kept); shift right 1; repeat W times.
//  RUN div: shift {rem,quo} left 1; trial = rem - divisor (W+1 bits). If non-negative, keep it
//    and set quo[0]=1; otherwise restore. Repeat W times.
//  FIX, signed ops:
//    mult: negate the 2W product if sign(a)^sign(b).
//    div: negate the quotient if sign(a)^sign(b); the remainder takes the sign of a.
//  Results: mult writes hi=prod[2W-1:W], lo=prod[W-1:0]; div writes lo=quotient, hi=remainder.
//  Timing: hi/lo are written at the FIX->IDLE edge, and done=1, busy=0 in that same cycle.
//    Start accepted at edge k -> busy high for cycles k+1..k+W+1 -> done in cycle k+W+2 (34 for W=32).
//  flush: in RUN or FIX, go to IDLE on the next edge with busy=0, done=0 and hi/lo unchanged.
//    flush in IDLE has no effect.
//  A flush together with start in IDLE: start is accepted.
//  MTHI/MTLO:
//    - In IDLE, wr_hi/wr_lo write wdata on the edge; both may be asserted in the same cycle.
//    - While busy, writes are dropped.
//    - A write in the done cycle applies normally (state is IDLE).
//  Arithmetic: the most negative value is handled via the W+1-bit magnitude (0x80000000 -> 2^31).
//    div 0x80000000 / -1 gives lo=0x80000000, hi=0.
//  Reset mid-operation aborts immediately to the reset values above.
// CONFIGURATION
//  `MULDIV_DIV0_EN defined:
//    - A div/divu accepted with b==0 skips RUN and FIX. The next cycle gives done=1, div0=1 and
//      busy never asserts; hi/lo are unchanged.
//    - div0 clears on the next accepted start or MTHI/MTLO write.
//  `MULDIV_DIV0_EN undefined:
//    - b==0 runs the full W+1 cycles with the restoring result: unsigned lo=all-ones, hi=a.
//    - Signed: the magnitude quotient is all-ones, lo=0xFFFFFFFF if a>=0 else 0x00000001, hi=a.
//    - div0 is tied 0.
// TESTING
//  mult a=7, b=0xFFFFFFFD -> done at cycle 34 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
//  div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  divu a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
//    A second start at cycle 5 is ignored.
//    MTLO 0x1234 at cycle 10 is dropped.
//  Load hi/lo via MTHI=0xAA, MTLO=0xBB; mult 3*5; flush at cycle 10 -> busy=0 at cycle 11,
//    no done pulse, hi=0xAA, lo=0xBB.
//  divu a=5, b=0 -> with MULDIV_DIV0_EN: done next cycle, div0=1, hi/lo unchanged;
//    without it: lo=0xFFFFFFFF, hi=5, done at cycle 34.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit: 1-bit-per-cycle shift-add multiplier, restoring divider, HI/LO.
// Optional MULDIV_DIV0_EN: divide by zero completes immediately with a sticky div0 flag.
module muldiv_seq #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [5:0]   func,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div0
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             is_div_q, neg_q, neg_rem_q;

    logic             op_legal, op_div, op_signed, accept, div0_hit;
    logic [W-1:0]     mag_a, mag_b, res_hi, res_lo;
    logic [W:0]       rem_sh, rem_diff, rem_new, mul_sum;
    logic             rem_ge;
    logic [2*W-1:0]   prod;

    always_comb begin
        op_legal  = 1'b1;
        op_div    = 1'b0;
        op_signed = 1'b0;
        unique case (func)
            6'b000111: op_signed = 1'b1;
            6'b001011: ;
            6'b010011: begin op_div = 1'b1; op_signed = 1'b1; end
            6'b100011: op_div = 1'b1;
            default:   op_legal = 1'b0;
        endcase
    end

    // -x of the most negative value wraps to itself, which read unsigned is exactly 2^(W-1)
    assign mag_a  = (op_signed && a[W-1]) ? -a : a;
    assign mag_b  = (op_signed && b[W-1]) ? -b : b;
    assign accept = (state_q == S_IDLE) && start && op_legal;

`ifdef MULDIV_DIV0_EN
    logic div0_q, div0_d;
    assign div0_hit = accept && op_div && (b == '0);
    always_comb begin
        div0_d = div0_q;
        if (div0_hit)
            div0_d = 1'b1;
        else if (accept || ((state_q == S_IDLE) && (wr_hi || wr_lo)))
            div0_d = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div0_q <= 1'b0;
        else        div0_q <= div0_d;
    end
    assign div0 = div0_q;
`else
    assign div0_hit = 1'b0;
    assign div0     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept && !div0_hit) state_d = S_RUN;
            S_RUN:   if (flush) state_d = S_IDLE;
                     else if (cnt_q == CNT_W'(W - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        rem_sh   = acc_q[2*W-1:W-1];
        rem_ge   = (rem_sh >= {1'b0, opnd_q});
        rem_diff = rem_sh - {1'b0, opnd_q};
        rem_new  = rem_ge ? rem_diff : rem_sh;
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    end

    // Mult: low half holds the multiplier; div: low half holds the dividend, filling with quotient bits
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        if (accept) begin
            acc_d  = {{W{1'b0}}, op_div ? mag_a : mag_b};
            opnd_d = op_div ? mag_b : mag_a;
            cnt_d  = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_div_q)
                acc_d = (2*W)'({rem_new, acc_q[W-2:0], rem_ge});
            else
                acc_d = {mul_sum, acc_q[W-1:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        if (is_div_q) begin
            res_lo = neg_q     ? -acc_q[W-1:0]   : acc_q[W-1:0];
            res_hi = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        end else begin
            res_lo = prod[W-1:0];
            res_hi = prod[2*W-1:W];
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = div0_hit;
        if ((state_q == S_FIX) && !flush) begin
            hi_d   = res_hi;
            lo_d   = res_lo;
            done_d = 1'b1;
        end else if (state_q == S_IDLE) begin
            if (wr_hi) hi_d = wdata;
            if (wr_lo) lo_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            if (accept) begin
                is_div_q  <= op_div;
                neg_q     <= op_signed && (a[W-1] ^ b[W-1]);
                neg_rem_q <= op_signed && a[W-1];
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latency, flush, MTHI/MTLO and reset cases.
module tb_muldiv_seq;

    localparam logic [5:0] F_MULT  = 6'b000111;
    localparam logic [5:0] F_MULTU = 6'b001011;
    localparam logic [5:0] F_DIV   = 6'b010011;
    localparam logic [5:0] F_DIVU  = 6'b100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  func = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        flush = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cyc, busy_cnt;
    logic saw_done;

    muldiv_seq #(.W(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .a(a), .b(b),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Cycle 1 is the cycle after the accepting edge; optional stray start / MTLO inside the run
    task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input int stray_at, input int wrlo_at,
                          output int dcyc, output int bcnt);
        logic [31:0] lo_before;
        int cyc;
        lo_before = lo;
        func = f; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        bcnt = 0;
        while (!done && cyc < 60) begin
            if (busy) bcnt++;
            if (cyc == wrlo_at + 1) check("mtlo_dropped", lo, lo_before);
            if (cyc == stray_at) begin
                func = F_MULTU; a = 32'd1; b = 32'd1; start = 1'b1;
            end
            if (cyc == wrlo_at) begin
                wr_lo = 1'b1; wdata = 32'h1234;
            end
            tick();
            start = 1'b0; wr_lo = 1'b0;
            cyc++;
        end
        dcyc = done ? cyc : -1;
        if (done) check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_div0", {31'd0, div0}, 32'd0);

        run_op(F_MULT, 32'd7, 32'hFFFF_FFFD, 0, 0, done_cyc, busy_cnt);
        check("mult_done_cyc", done_cyc, 32'd34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, done_cyc, busy_cnt);
        check("multu_busy_cnt", busy_cnt, 32'd33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, done_cyc, busy_cnt);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(F_DIVU, 32'd100, 32'd7, 5, 10, done_cyc, busy_cnt);
        check("divu_done_cyc", done_cyc, 32'd34);
        check("divu_lo", lo, 32'h0000_000E);
        check("divu_hi", hi, 32'h0000_0002);
        tick();
        check("stray_start_ignored", {31'd0, busy}, 32'd0);

        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, done_cyc, busy_cnt);
        check("div_min_lo", lo, 32'h8000_0000);
        check("div_min_hi", hi, 32'd0);

        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, done_cyc, busy_cnt);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'd0);

        // Illegal func must not start anything
        func = 6'b100000; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("illegal_no_busy", {31'd0, busy}, 32'd0);
        tick();
        check("illegal_no_done", {31'd0, done}, 32'd0);

        // MTHI and MTLO together, then a flushed mult
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hAA;
        tick();
        wr_lo = 1'b0; wdata = 32'hBB; wr_hi = 1'b0; wr_lo = 1'b1;
        tick();
        wr_lo = 1'b0;
        check("mthi", hi, 32'hAA);
        check("mtlo", lo, 32'hBB);
        func = F_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("flush_no_done", {31'd0, saw_done}, 32'd0);
        check("flush_hi", hi, 32'hAA);
        check("flush_lo", lo, 32'hBB);

`ifdef MULDIV_DIV0_EN
        run_op(F_DIVU, 32'd5, 32'd0, 0, 0, done_cyc, busy_cnt);
        check("div0_done_cyc", done_cyc, 32'd1);
        check("div0_busy_cnt", busy_cnt, 32'd0);
        check("div0_flag", {31'd0, div0}, 32'd1);
        check("div0_hi", hi, 32'hAA);
        check("div0_lo", lo, 32'hBB);
        wr_hi = 1'b1; wdata = 32'hCC;
        tick();
        wr_hi = 1'b0;
        check("div0_clear", {31'd0, div0}, 32'd0);
        check("div0_mthi", hi, 32'hCC);
`else
        run_op(F_DIVU, 32'd5, 32'd0, 0, 0, done_cyc, busy_cnt);
        check("divu0_done_cyc", done_cyc, 32'd34);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd5);
        check("divu0_flag", {31'd0, div0}, 32'd0);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0, done_cyc, busy_cnt);
        check("div0_neg_lo", lo, 32'h0000_0001);
        check("div0_neg_hi", hi, 32'hFFFF_FFF9);
`endif

        // MTHI in the done cycle applies
        run_op(F_MULTU, 32'd3, 32'd5, 0, 0, done_cyc, busy_cnt);
        check("done_cyc_lo", lo, 32'd15);
        wr_hi = 1'b1; wdata = 32'h77;
        tick();
        wr_hi = 1'b0;
        check("done_cyc_mthi", hi, 32'h77);
        check("done_cyc_lo_kept", lo, 32'd15);

        // Reset in the middle of an operation
        func = F_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
